// File: rtl/mod_inv_bin.sv
// Modular inverse r = a^-1 mod p by the binary extended Euclidean method.
// The modulus must be odd. Internal values are kept in [0, p-1] on every
// iteration, so the result needs no final reduction.
module mod_inv_bin #(
  parameter int unsigned K     = 256,
  parameter int unsigned CNT_W = $clog2(4*K+8)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] p,
  output logic         ready,
  output logic         busy,
  output logic [K-1:0] r,
  output logic         no_inv,
  output logic         valid_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_SUB,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(4*K+4);
  localparam logic [K-1:0]     ONE      = K'(1);
  localparam logic [K-1:0]     THREE    = K'(3);

  state_e           state_q, state_d;
  logic [K-1:0]     u_q, u_d;
  logic [K-1:0]     v_q, v_d;
  logic [K-1:0]     x_q, x_d;
  logic [K-1:0]     y_q, y_d;
  logic [K-1:0]     p_q, p_d;
  logic [K-1:0]     r_q, r_d;
  logic             no_inv_q, no_inv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_err;
  logic wd_hit;
  logic u_one, v_one, u_zero, v_zero;

  // Halve val modulo the odd modulus m; the odd case adds m in K+1 bits first.
  function automatic logic [K-1:0] half_mod(input logic [K-1:0] val,
                                            input logic [K-1:0] m);
    logic [K:0] s;
    s = val[0] ? ({1'b0, val} + {1'b0, m}) : {1'b0, val};
    return s[K:1];
  endfunction

  // (lhs - rhs) mod m for lhs, rhs already in [0, m-1].
  function automatic logic [K-1:0] sub_mod(input logic [K-1:0] lhs,
                                           input logic [K-1:0] rhs,
                                           input logic [K-1:0] m);
    logic [K:0] d;
    d = {1'b0, lhs} - {1'b0, rhs};
    if (lhs < rhs) d = d + {1'b0, m};
    return d[K-1:0];
  endfunction

  // u and v already hold a and p from the accepting edge, so the error
  // checks in CHECK read them directly instead of separate operand copies.
  assign in_err = !p_q[0] || (p_q < THREE) || (u_q == '0) || (u_q >= p_q);
  assign wd_hit = (cnt_q == WD_LIMIT);
  assign u_one  = (u_q == ONE);
  assign v_one  = (v_q == ONE);
  assign u_zero = (u_q == '0);
  assign v_zero = (v_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = in_err ? S_DONE : S_SHIFT;
      S_SHIFT: begin
        if (wd_hit || u_one || v_one || u_zero || v_zero) state_d = S_DONE;
        else if (u_q[0] && v_q[0])                        state_d = S_SUB;
      end
      S_SUB:   state_d = wd_hit ? S_DONE : S_SHIFT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; result and flag come from registers.
  always_comb begin
    ready     = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    valid_out = (state_q == S_DONE);
    r         = r_q;
    no_inv    = no_inv_q;
  end

  // Datapath next-state: operand capture, iteration updates, result latch.
  always_comb begin
    u_d      = u_q;
    v_d      = v_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    r_d      = r_q;
    no_inv_d = no_inv_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          u_d   = a;
          v_d   = p;
          p_d   = p;
          x_d   = '0;
          y_d   = '0;
          cnt_d = '0;
        end
      end
      S_CHECK: begin
        x_d   = ONE;
        y_d   = '0;
        cnt_d = '0;
        if (in_err) begin
          r_d      = '0;
          no_inv_d = 1'b1;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wd_hit) begin
          r_d      = '0;
          no_inv_d = 1'b1;
        end else if (u_one) begin
          r_d      = x_q;
          no_inv_d = 1'b0;
        end else if (v_one) begin
          r_d      = y_q;
          no_inv_d = 1'b0;
        end else if (u_zero || v_zero) begin
          r_d      = '0;
          no_inv_d = 1'b1;
        end else begin
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            x_d = half_mod(x_q, p_q);
          end
          if (!v_q[0]) begin
            v_d = v_q >> 1;
            y_d = half_mod(y_q, p_q);
          end
        end
      end
      S_SUB: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wd_hit) begin
          r_d      = '0;
          no_inv_d = 1'b1;
        end else if (u_q >= v_q) begin
          u_d = u_q - v_q;
          x_d = sub_mod(x_q, y_q, p_q);
        end else begin
          v_d = v_q - u_q;
          y_d = sub_mod(y_q, x_q, p_q);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q      <= '0;
      v_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      no_inv_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      u_q      <= u_d;
      v_q      <= v_d;
      x_q      <= x_d;
      y_q      <= y_d;
      p_q      <= p_d;
      r_q      <= r_d;
      no_inv_q <= no_inv_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mod_inv_bin.sv
// Directed bench for mod_inv_bin at K=8.
module tb_mod_inv_bin;

  localparam int unsigned K      = 8;
  localparam int          LAT_MAX = 4*K+4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [K-1:0] a;
  logic [K-1:0] p;
  logic         ready;
  logic         busy;
  logic [K-1:0] r;
  logic         no_inv;
  logic         valid_out;

  int n_cmp;
  int n_bad;

  mod_inv_bin #(.K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .p         (p),
    .ready     (ready),
    .busy      (busy),
    .r         (r),
    .no_inv    (no_inv),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request at a falling edge and wait for the completion pulse.
  // lat counts falling edges after the accepting edge up to the one that
  // first sees valid_out; to is set if the bound expires.
  task automatic run_op(input logic [K-1:0] ai, input logic [K-1:0] pi,
                        output logic [K-1:0] ro, output logic nio,
                        output int lat, output logic to);
    int w;
    w = 0;
    while (!ready && w < 2*LAT_MAX) begin
      @(negedge clk);
      w++;
    end
    start = 1'b1;
    a     = ai;
    p     = pi;
    lat   = 0;
    to    = 1'b0;
    @(negedge clk);
    lat   = 1;
    start = 1'b0;
    a     = $urandom_range(255, 0);
    p     = $urandom_range(255, 0);
    while (!valid_out && lat <= LAT_MAX + 2) begin
      @(negedge clk);
      lat++;
    end
    to  = !valid_out;
    ro  = r;
    nio = no_inv;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    p     = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready, busy, valid_out, no_inv, r} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset: rdy/busy/vld/ni/r got %b%b%b%b %0d want 1000 0",
               ready, busy, valid_out, no_inv, r);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_inverse;
    logic [K-1:0] va [6];
    logic [K-1:0] vp [6];
    logic [K-1:0] vr [6];
    logic [K-1:0] ro;
    logic nio, to;
    int lat;
    // a, p, expected inverse (checked by hand: a*r mod p == 1)
    va = '{8'd3, 8'd1,  8'd5,  8'd2,   8'd254, 8'd3};
    vp = '{8'd7, 8'd13, 8'd11, 8'd255, 8'd255, 8'd251};
    vr = '{8'd5, 8'd1,  8'd9,  8'd128, 8'd254, 8'd84};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vp[i], ro, nio, lat, to);
      n_cmp++;
      if (to || ro !== vr[i] || nio !== 1'b0 || lat > LAT_MAX) begin
        n_bad++;
        $display("FAIL inverse a=%0d p=%0d: got r=%0d ni=%b lat=%0d to=%b want r=%0d ni=0 lat<=%0d",
                 va[i], vp[i], ro, nio, lat, to, vr[i], LAT_MAX);
      end
      if (i == 0) begin
        @(negedge clk);
        n_cmp++;
        if (valid_out !== 1'b0 || ready !== 1'b1 || r !== 8'd5) begin
          n_bad++;
          $display("FAIL pulse_width: vld=%b rdy=%b r=%0d want vld=0 rdy=1 r=5",
                   valid_out, ready, r);
        end
      end
    end
  endtask

  task automatic test_no_inv;
    logic [K-1:0] ro;
    logic nio, to;
    int lat;
    run_op(8'd6, 8'd9, ro, nio, lat, to);
    n_cmp++;
    if (to || ro !== 8'd0 || nio !== 1'b1 || lat > LAT_MAX) begin
      n_bad++;
      $display("FAIL gcd a=6 p=9: got r=%0d ni=%b lat=%0d to=%b want r=0 ni=1 lat<=%0d",
               ro, nio, lat, to, LAT_MAX);
    end
  endtask

  task automatic test_input_err;
    logic [K-1:0] va [5];
    logic [K-1:0] vp [5];
    logic [K-1:0] ro;
    logic nio, to;
    int lat;
    va = '{8'd3,  8'd0, 8'd7, 8'd9, 8'd1};
    vp = '{8'd10, 8'd7, 8'd7, 8'd7, 8'd1};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vp[i], ro, nio, lat, to);
      n_cmp++;
      if (to || ro !== 8'd0 || nio !== 1'b1 || lat !== 2) begin
        n_bad++;
        $display("FAIL input_err a=%0d p=%0d: got r=%0d ni=%b lat=%0d want r=0 ni=1 lat=2",
                 va[i], vp[i], ro, nio, lat);
      end
    end
    // smallest legal modulus is not an error: 2*2 = 4 = 1 mod 3
    run_op(8'd2, 8'd3, ro, nio, lat, to);
    n_cmp++;
    if (to || ro !== 8'd2 || nio !== 1'b0) begin
      n_bad++;
      $display("FAIL min_mod a=2 p=3: got r=%0d ni=%b want r=2 ni=0", ro, nio);
    end
  endtask

  task automatic test_busy_ignore;
    int pulses;
    logic [K-1:0] rseen;
    @(negedge clk);
    start = 1'b1; a = 8'd3; p = 8'd7;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_after_accept: busy=%b rdy=%b want 1 0", busy, ready);
    end
    start = 1'b1; a = 8'd2; p = 8'd13;
    repeat (2) @(negedge clk);
    start = 1'b0;
    pulses = 0;
    rseen  = '0;
    for (int i = 0; i < 40; i++) begin
      if (valid_out) begin
        pulses++;
        rseen = r;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (pulses !== 1 || rseen !== 8'd5) begin
      n_bad++;
      $display("FAIL busy_ignore: pulses=%0d r=%0d want pulses=1 r=5", pulses, rseen);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    logic [K-1:0] ro;
    logic nio, to;
    int lat;
    @(negedge clk);
    start = 1'b1; a = 8'd2; p = 8'd255;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ready, busy, valid_out, no_inv, r} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: rdy/busy/vld/ni/r got %b%b%b%b %0d want 1000 0",
               ready, busy, valid_out, no_inv, r);
    end
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_abort: valid pulses=%0d want 0", pulses);
    end
    run_op(8'd3, 8'd7, ro, nio, lat, to);
    n_cmp++;
    if (to || ro !== 8'd5 || nio !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset a=3 p=7: got r=%0d ni=%b to=%b want r=5 ni=0", ro, nio, to);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    logic stable;
    @(negedge clk);
    start = 1'b1; a = 8'd3; p = 8'd7;
    @(negedge clk);
    a = 8'd2; p = 8'd7;
    w = 0;
    while (!valid_out && w < LAT_MAX + 4) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (valid_out !== 1'b1 || r !== 8'd5 || no_inv !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first: vld=%b r=%0d ni=%b want 1 5 0", valid_out, r, no_inv);
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: rdy=%b want 1", ready);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept: busy=%b rdy=%b want 1 0", busy, ready);
    end
    start  = 1'b0;
    stable = 1'b1;
    w = 0;
    while (!valid_out && w < LAT_MAX + 4) begin
      if (r !== 8'd5 || no_inv !== 1'b0) stable = 1'b0;
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL b2b_hold: r/no_inv changed between pulses, want r=5 ni=0 held");
    end
    n_cmp++;
    if (valid_out !== 1'b1 || r !== 8'd4 || no_inv !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: vld=%b r=%0d ni=%b want 1 4 0", valid_out, r, no_inv);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_inverse();
    test_no_inv();
    test_input_err();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_inv_bin.md
MOD_INV_BIN -- requirements
Module: mod_inv_bin

Interface
REQ-001 Parameter K, default 256: operand width in bits; legal values 8..4096.
REQ-002 Parameter CNT_W, default $clog2(4*K+8): width of the internal iteration counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 a  input  K  operand to invert.
REQ-007 p  input  K  modulus.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE has been exited.
REQ-010 r  output  K  result a^-1 mod p, in range [1, p-1].
REQ-011 no_inv  output  1  error flag, qualified by valid_out.
REQ-012 valid_out  output  1  one-cycle completion pulse.

Function
REQ-013 Start handling: start=1 with ready=1 at a rising edge accepts the request and captures a and p into internal registers.
- Inputs may change freely after acceptance.
- start while ready=0 is ignored; no queuing.
REQ-014 States and transitions:
- IDLE -> CHECK on an accepted start.
- CHECK -> DONE on an input error, otherwise CHECK -> SHIFT.
- SHIFT <-> SUB during iteration.
- SHIFT -> DONE on termination.
- DONE -> IDLE unconditionally.
REQ-015 Input errors detected in CHECK (any one forces no_inv=1, r=0):
- p[0]=0, or p<3
- a=0
- a>=p
REQ-016 CHECK initialisation on no error: u=a, v=p, x=1, y=0.
REQ-017 SHIFT, evaluated in priority order:
- u==1: result x.
- v==1: result y.
- u==0 or v==0: no_inv.
- Otherwise, in the same cycle: if u even, u=u>>1 and x=(x even ? x>>1 : (x+p)>>1). If v even, v=v>>1 and y, likewise.
- If u and v are both odd, go to SUB and update nothing.
REQ-018 (x+p) and (y+p) SHALL be computed K+1 bits wide; no carry loss.
REQ-019 SUB, then return to SHIFT:
- If u>=v: u=u-v and x=(x>=y ? x-y : x-y+p).
- Else: v=v-u and y=(y>=x ? y-x : y-x+p).
REQ-020 Invariant: x and y stay in [0, p-1] at every cycle; no final reduction step exists or is needed.
REQ-021 gcd(a,p)>1 SHALL terminate through the u==0 or v==0 branch with no_inv=1 and r=0.
REQ-022 Latency is counted in cycles from the accepting edge to the valid_out cycle:
- input error: exactly 2;
- otherwise at most 4*K+4.
REQ-023 Watchdog: if the counter reaches 4*K+4 in SHIFT or SUB, go to DONE with no_inv=1 and r=0; this is unreachable for legal inputs.
REQ-024 DONE: valid_out=1 for exactly one cycle; r and no_inv update in the same cycle.
REQ-025 r and no_inv hold their values until the next DONE.
REQ-026 ready returns to 1 the cycle after DONE, so a back-to-back start is accepted then.

Reset
REQ-027 While rst_n=0, asynchronously:
- state=IDLE
- ready=1, busy=0, valid_out=0, no_inv=0, r=0
- all internal registers and the counter = 0
REQ-028 Reset asserted mid-operation SHALL abort the operation without a valid_out pulse.
REQ-029 The first start accepted after rst_n deasserts is processed normally.

Verification
REQ-030 K=8, a=3, p=7 -> valid_out pulse, r=5, no_inv=0. a=1, p=13 -> r=1.
REQ-031 K=8, a=6, p=9 -> no_inv=1, r=0 within the latency bound. p=10 or a=0 or a=p -> no_inv=1, valid_out exactly 2 cycles after acceptance.
REQ-032 K=256, 1000 random pairs (odd p, 0<a<p) -> r matches the golden model; gcd>1 cases flag no_inv; every latency <= 1028.
REQ-033 start pulsed while busy with different a/p -> ignored; first result unchanged; exactly one valid_out.
REQ-034 rst_n pulsed low mid-iteration -> outputs go to reset values immediately, no valid_out; the next start (a=3, p=7) returns r=5.
REQ-035 Back-to-back starts, start held high -> second request accepted the cycle ready rises; r and no_inv stable between pulses.
